// File: rtl/fifo_stream_if.sv
// Handshake bundle between the FIFO read-side adapter, the upstream show-ahead FIFO
// and the downstream valid/ready consumer.
interface fifo_stream_if #(
    parameter int WIDTH = 8,
    parameter int W_PKT = 16
);
    logic [WIDTH-1:0] fifo_data_i;
    logic             fifo_empty_i;
    logic             fifo_rd_en_o;
    logic [WIDTH-1:0] m_data_o;
    logic             m_valid_o;
    logic             m_last_o;
    logic             m_ready_i;
    logic [W_PKT-1:0] pkt_cnt_o;

    modport master (
        input  fifo_data_i, fifo_empty_i, m_ready_i,
        output fifo_rd_en_o, m_data_o, m_valid_o, m_last_o, pkt_cnt_o
    );

    modport slave (
        output fifo_data_i, fifo_empty_i, m_ready_i,
        input  fifo_rd_en_o, m_data_o, m_valid_o, m_last_o, pkt_cnt_o
    );
endinterface

// File: rtl/fifo_stream_out.sv
// Pops a show-ahead FIFO into a 2-entry head/skid buffer and presents it as a registered
// valid/ready stream, tagging every BURST_LEN-th word as last and counting completed bursts.
module fifo_stream_out #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int W_PKT     = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    fifo_stream_if.master bus
);
    localparam int            BW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e             occ_q, occ_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [W_PKT-1:0] pkt_q, pkt_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             head_last_q, head_last_d;
    logic             skid_last_q, skid_last_d;
    logic             push_s;
    logic             fire_s;
    logic             push_last_s;

    // Pop decision uses only registered occupancy, so m_ready_i never reaches fifo_rd_en_o.
    assign push_s      = ~bus.fifo_empty_i && (occ_q != OCC_FULL);
    assign fire_s      = (occ_q != OCC_EMPTY) && bus.m_ready_i;
    assign push_last_s = (beat_q == BEAT_MAX);

    // Occupancy transitions, entry steering, burst tagging and burst counting.
    always_comb begin
        occ_d       = occ_q;
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        beat_d      = beat_q;
        pkt_d       = pkt_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push_s) begin
                    occ_d       = OCC_ONE;
                    head_data_d = bus.fifo_data_i;
                    head_last_d = push_last_s;
                end else begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_ONE: begin
                if (push_s && fire_s) begin
                    occ_d       = OCC_ONE;
                    head_data_d = bus.fifo_data_i;
                    head_last_d = push_last_s;
                end else if (push_s) begin
                    occ_d       = OCC_FULL;
                    skid_data_d = bus.fifo_data_i;
                    skid_last_d = push_last_s;
                end else if (fire_s) begin
                    occ_d = OCC_EMPTY;
                end else begin
                    occ_d = OCC_ONE;
                end
            end
            OCC_FULL: begin
                if (fire_s) begin
                    occ_d       = OCC_ONE;
                    head_data_d = skid_data_q;
                    head_last_d = skid_last_q;
                end else begin
                    occ_d = OCC_FULL;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
        if (push_s) begin
            beat_d = push_last_s ? {BW{1'b0}} : beat_q + BW'(1);
        end else begin
            beat_d = beat_q;
        end
        if (fire_s && head_last_q) begin
            pkt_d = pkt_q + W_PKT'(1);
        end else begin
            pkt_d = pkt_q;
        end
    end

    // Control state with synchronous reset; head_last is cleared so m_last_o is low out of reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            occ_q       <= OCC_EMPTY;
            beat_q      <= {BW{1'b0}};
            pkt_q       <= {W_PKT{1'b0}};
            head_last_q <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            beat_q      <= beat_d;
            pkt_q       <= pkt_d;
            head_last_q <= head_last_d;
        end
    end

    // Entry payload registers carry no reset.
    always_ff @(posedge clk_i) begin
        head_data_q <= head_data_d;
        skid_data_q <= skid_data_d;
        skid_last_q <= skid_last_d;
    end

    assign bus.fifo_rd_en_o = push_s;
    assign bus.m_data_o     = head_data_q;
    assign bus.m_last_o     = head_last_q;
    assign bus.m_valid_o    = (occ_q != OCC_EMPTY);
    assign bus.pkt_cnt_o    = pkt_q;
endmodule
